// File: rtl/counter_sl_if.sv
// counter_sl_if -- bundles the counter's enable input and its observable state.
//   en    : count enable, driven by the master, sampled by the counter on rising clk
//   count : 4-bit counter value (bit 0 is LSB), driven by the counter
//   tc    : terminal count (en AND count==4'hF), driven by the counter
// Modports: master (drives en, observes count/tc), slave (the counter itself).
interface counter_sl_if;
  logic       en;
  logic [3:0] count;
  logic       tc;

  modport master (output en, input count, input tc);
  modport slave  (input en, output count, output tc);
endinterface

// File: rtl/counter_sl.sv
// counter_sl -- 4-bit synchronous up-counter built purely from pmos/nmos switches.
//   clk   : clock; state advances on the rising edge
//   reset : synchronous active-high clear (wins over en)
//   bus   : counter_sl_if.slave -- en in, count/tc out
// Each bit is a master-slave transmission-gate flip-flop (input inverter, master
// latch open while clk=0, slave latch open while clk=1, output inverter) fed by
// static complementary CMOS next-state logic:
//   carry[i+1] = carry[i] & count[i], carry[0] = en   (ripple toggle chain)
//   next[i]    = ~reset & (count[i] ^ carry[i])
// tc is simply carry[4]: en with all four bits set, independent of reset.
// The few assign statements below are pure wire aliases, no logic.
module counter_sl (
  input  logic        clk,
  input  logic        reset,
  counter_sl_if.slave bus
);
  supply1 vdd;
  supply0 gnd;

  wire       clk_bar;
  wire [4:0] carry;
  wire [3:0] count_reg;

  // Single shared clk_bar driver; clk itself is never gated.
  pmos (clk_bar, vdd, clk);
  nmos (clk_bar, gnd, clk);

  assign carry[0]  = bus.en;
  assign bus.count = count_reg;
  assign bus.tc    = carry[4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      // next-state logic nets (*_s are series-stack internal nodes)
      wire cy_n, cy_s, cy;
      wire xa, xa_s, xb, xb_s, xc, xc_s, xn, xn_s;
      wire count_next, nx_s;
      // flip-flop nets
      wire d_bar, m, m_bar, m_fb, s, s_bar, s_fb, q;

      // Carry out: NAND2 + inverter
      pmos (cy_n, vdd,  carry[gi]);
      pmos (cy_n, vdd,  count_reg[gi]);
      nmos (cy_n, cy_s, carry[gi]);
      nmos (cy_s, gnd,  count_reg[gi]);
      pmos (cy,   vdd,  cy_n);
      nmos (cy,   gnd,  cy_n);

      // XNOR(count, carry) from four NOR2 gates
      pmos (xa_s, vdd,  count_reg[gi]);
      pmos (xa,   xa_s, carry[gi]);
      nmos (xa,   gnd,  count_reg[gi]);
      nmos (xa,   gnd,  carry[gi]);

      pmos (xb_s, vdd,  count_reg[gi]);
      pmos (xb,   xb_s, xa);
      nmos (xb,   gnd,  count_reg[gi]);
      nmos (xb,   gnd,  xa);

      pmos (xc_s, vdd,  carry[gi]);
      pmos (xc,   xc_s, xa);
      nmos (xc,   gnd,  carry[gi]);
      nmos (xc,   gnd,  xa);

      pmos (xn_s, vdd,  xb);
      pmos (xn,   xn_s, xc);
      nmos (xn,   gnd,  xb);
      nmos (xn,   gnd,  xc);

      // next = NOR(reset, xnor) = ~reset & (count ^ carry); reset forces 0
      pmos (nx_s,       vdd,  reset);
      pmos (count_next, nx_s, xn);
      nmos (count_next, gnd,  reset);
      nmos (count_next, gnd,  xn);

      // Flip-flop input inverter
      pmos (d_bar, vdd, count_next);
      nmos (d_bar, gnd, count_next);

      // Master latch: samples d_bar while clk=0, holds via feedback while clk=1
      nmos (m, d_bar, clk_bar);
      pmos (m, d_bar, clk);
      pmos (m_bar, vdd, m);
      nmos (m_bar, gnd, m);
      pmos (m_fb, vdd, m_bar);
      nmos (m_fb, gnd, m_bar);
      nmos (m, m_fb, clk);
      pmos (m, m_fb, clk_bar);

      // Slave latch: follows master while clk=1, holds via feedback while clk=0,
      // so the output only moves in the half-cycle after a rising edge.
      nmos (s, m_bar, clk);
      pmos (s, m_bar, clk_bar);
      pmos (s_bar, vdd, s);
      nmos (s_bar, gnd, s);
      pmos (s_fb, vdd, s_bar);
      nmos (s_fb, gnd, s_bar);
      nmos (s, s_fb, clk_bar);
      pmos (s, s_fb, clk);

      // Output inverter isolates the stored node from the next-state load
      pmos (q, vdd, s_bar);
      nmos (q, gnd, s_bar);

      assign carry[gi+1]   = cy;
      assign count_reg[gi] = q;
    end
  endgenerate
endmodule

// File: tb/tb_counter_sl.sv
// tb_counter_sl -- directed-vector bench for counter_sl with a queue scoreboard.
// The stimulus process drives reset/en on each falling edge and pushes the
// expected pre-edge and post-edge view of count/tc; the monitor pops one entry
// per cycle and compares in the settled window before the rising edge and
// just after it.
module tb_counter_sl;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  counter_sl_if bus ();

  counter_sl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    bit         pre_valid;
    logic [3:0] pre_count;
    logic       pre_tc;
    logic [3:0] post_count;
    logic       post_tc;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         txn    = 0;
  logic [3:0] model  = 4'h0;
  bit         model_valid = 1'b0;

  function automatic void check4(string name, logic [3:0] act, logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: count=%h required=%h at t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void check1(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: tc=%b required=%b at t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void check_known(string name, logic [3:0] act);
    checks++;
    if ($isunknown(act)) begin
      errors++;
      $display("FAIL %s: count=%b required no X/Z at t=%0t", name, act, $time);
    end
  endfunction

  // Drive one cycle of stimulus on the falling edge and record what the
  // counter must show before and after the following rising edge.
  task automatic step(input logic r, input logic e);
    exp_t       x;
    logic [3:0] nxt;
    @(negedge clk);
    reset  = r;
    bus.en = e;
    if (r)      nxt = 4'h0;
    else if (e) nxt = model + 4'h1;
    else        nxt = model;
    x.rst        = r;
    x.en         = e;
    x.pre_valid  = model_valid;
    x.pre_count  = model;
    x.pre_tc     = e & (model == 4'hF);
    x.post_count = nxt;
    x.post_tc    = e & (nxt == 4'hF);
    if (model_valid || r) exp_q.push_back(x);
    model       = nxt;
    model_valid = model_valid | r;
  endtask

  task automatic run(input logic r, input logic e, input int n);
    for (int k = 0; k < n; k++) step(r, e);
  endtask

  // Hand-computed endpoint of a scenario, sampled just after the edge.
  task automatic check_now(input string name, input logic [3:0] req);
    @(posedge clk);
    #2;
    check4(name, bus.count, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.pre_valid) begin
          check_known("pre_edge_known", bus.count);
          check4("pre_edge_count", bus.count, e.pre_count);
          check1("pre_edge_tc", bus.tc, e.pre_tc);
        end
        @(posedge clk);
        #1;
        check_known("post_edge_known", bus.count);
        check4("post_edge_count", bus.count, e.post_count);
        check1("post_edge_tc", bus.tc, e.post_tc);
        txn++;
        $display("txn %0d: reset=%b en=%b count=%h tc=%b (expect %h/%b)",
                 txn, e.rst, e.en, bus.count, bus.tc, e.post_count, e.post_tc);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.en = 1'b0;

    // Reset together with en=1, then 19 increments: 0,1..F,0,1,2,3
    step(1'b1, 1'b1);
    run(1'b0, 1'b1, 19);
    check_now("seq20_end", 4'h3);

    // Count to 5 then hold for 5 edges
    step(1'b1, 1'b0);
    run(1'b0, 1'b1, 5);
    run(1'b0, 1'b0, 5);
    check_now("hold_at_5", 4'h5);

    // Reach F, then reset and en on the same edge: reset wins
    step(1'b1, 1'b0);
    run(1'b0, 1'b1, 15);
    step(1'b1, 1'b1);
    check_now("reset_beats_wrap", 4'h0);

    // Natural wrap F -> 0
    run(1'b0, 1'b1, 15);
    step(1'b0, 1'b1);
    check_now("wrap_to_0", 4'h0);

    // Mid-count reset at 9 with en=1, then release
    step(1'b1, 1'b0);
    run(1'b0, 1'b1, 9);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check_now("reset_release", 4'h1);

    // Alternating en 1,0 for 8 cycles from 0
    step(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, (k % 2 == 0) ? 1'b1 : 1'b0);
    check_now("alternating_en", 4'h4);

    // Long hold at 7
    run(1'b0, 1'b1, 3);
    run(1'b0, 1'b0, 12);
    check_now("long_hold_7", 4'h7);

    // Let the monitor drain the last entry
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
